// File: rtl/alu_pkg.sv
// Shared op encodings and FSM state type for the handshaked sequential ALU.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_RSV = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier producing the low WIDTH bits of a*b, one multiplier bit per cycle.
// Only instantiated when ALU_MUL_EN is defined.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             r_busy;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_accNext;

    // done is raised during the last step so the caller can register the final sum on that edge
    assign w_accNext = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign done      = r_busy && (r_cnt == LAST);
    assign product   = w_accNext;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_busy) begin
            r_acc    <= w_accNext;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered, held results; optional multi-cycle multiply under ALU_MUL_EN
// (undefined: op 011 behaves as the reserved op).
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit SLT_SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             ovf
);

    state_t           r_state;
    state_t           w_stateNext;
    logic [WIDTH-1:0] r_res;
    logic             r_zero;
    logic             r_ovf;
    logic             r_outValid;

    logic             w_accept;
    logic             w_mulStart;
    logic             w_singleLoad;
    logic             w_mulDone;
    logic [WIDTH-1:0] w_mulProduct;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_lt;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;

    assign in_ready     = (r_state == IDLE) && (!r_outValid || out_ready);
    assign w_accept     = in_valid && in_ready;
    assign w_singleLoad = w_accept && !w_mulStart;

    assign w_sum  = a + b;
    assign w_diff = a - b;
    assign w_lt   = SLT_SIGNED ? ($signed(a) < $signed(b)) : (a < b);

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (op)
            OP_AND: w_res = a & b;
            OP_OR:  w_res = a | b;
            OP_ADD: begin
                w_res = w_sum;
                w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_XOR: w_res = a ^ b;
            OP_SUB: begin
                w_res = w_diff;
                w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: w_res = {{(WIDTH-1){1'b0}}, w_lt};
            OP_MUL, OP_RSV: w_res = '0;
            default: w_res = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    assign w_mulStart = w_accept && (op == OP_MUL);

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_mulStart),
        .a       (a),
        .b       (b),
        .done    (w_mulDone),
        .product (w_mulProduct)
    );
`else
    assign w_mulStart   = 1'b0;
    assign w_mulDone    = 1'b0;
    assign w_mulProduct = '0;
`endif

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (w_mulStart) w_stateNext = MUL;
            MUL:     if (w_mulDone)  w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // A multiply entry with a simultaneous consume falls through to the clear branch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_res      <= '0;
            r_zero     <= 1'b0;
            r_ovf      <= 1'b0;
            r_outValid <= 1'b0;
        end else if (w_singleLoad) begin
            r_res      <= w_res;
            r_zero     <= (w_res == '0);
            r_ovf      <= w_ovf;
            r_outValid <= 1'b1;
        end else if (w_mulDone) begin
            r_res      <= w_mulProduct;
            r_zero     <= (w_mulProduct == '0);
            r_ovf      <= 1'b0;
            r_outValid <= 1'b1;
        end else if (r_outValid && out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign res       = r_res;
    assign zero      = r_zero;
    assign ovf       = r_ovf;
    assign out_valid = r_outValid;

endmodule
